// File: rtl/sseg_value_driver_if.sv
// Handshake and digit-drive bundle between a value source and sseg_value_driver.
// The source owns value/valid; the driver owns ready and the per-digit encoder inputs.
interface sseg_value_driver_if;
   logic [13:0] value;
   logic        valid;
   logic        ready;
   logic [15:0] dig_bin;
   logic [3:0]  dig_neg;
   logic [3:0]  dig_en;

   modport master (
      output value, valid,
      input  ready, dig_bin, dig_neg, dig_en
   );

   modport slave (
      input  value, valid,
      output ready, dig_bin, dig_neg, dig_en
   );
endinterface

// File: rtl/sseg_value_driver.sv
// Signed 14-bit value -> four-digit 7-segment encoder drive: double-dabble BCD
// conversion followed by leading-zero blanking, minus placement and overflow dashes.
module sseg_value_driver (
   input  logic                 clk,
   input  logic                 rst,
   sseg_value_driver_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      FORMAT  = 2'd2
   } state_t;

   state_t      state, state_d;
   logic        neg_q, neg_d;
   logic [13:0] mag_q, mag_d;
   logic [15:0] bcd_q, bcd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] bin_q, bin_d;
   logic [3:0]  dneg_q, dneg_d;
   logic [3:0]  en_q, en_d;

   logic [15:0] adj;
   logic [1:0]  msd;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         neg_q  <= 1'b0;
         mag_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         bin_q  <= '0;
         dneg_q <= '0;
         en_q   <= 4'b0001;
      end else begin
         state  <= state_d;
         neg_q  <= neg_d;
         mag_q  <= mag_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         bin_q  <= bin_d;
         dneg_q <= dneg_d;
         en_q   <= en_d;
      end
   end

   always_comb begin
      state_d = state;
      neg_d   = neg_q;
      mag_d   = mag_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      dneg_d  = dneg_q;
      en_d    = en_q;
      adj     = bcd_q;
      msd     = '0;

      case (state)
         IDLE: begin
            if (bus.valid) begin
               neg_d   = bus.value[13];
               // -8192 negates to itself, which reads as 8192 unsigned
               mag_d   = bus.value[13] ? 14'(-bus.value) : bus.value;
               bcd_d   = '0;
               cnt_d   = 4'd14;
               state_d = CONVERT;
            end
         end

         CONVERT: begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (bcd_q[4*i +: 4] >= 4'd5)
                  adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
            {bcd_d, mag_d} = {adj[14:0], mag_q, 1'b0};
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1)
               state_d = FORMAT;
         end

         FORMAT: begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (bcd_q[4*i +: 4] != 4'd0)
                  msd = 2'(i);
            end
            bin_d  = '0;
            dneg_d = '0;
            en_d   = '0;
            // Negative magnitudes above 999 leave no room for the minus sign
            if (neg_q && (bcd_q[15:12] != 4'd0)) begin
               dneg_d = '1;
               en_d   = '1;
            end else begin
               for (int unsigned i = 0; i < 4; i++) begin
                  if (i <= 32'(msd)) begin
                     en_d[i]        = 1'b1;
                     bin_d[4*i +: 4] = bcd_q[4*i +: 4];
                  end else if (neg_q && (i == 32'(msd) + 32'd1)) begin
                     en_d[i]   = 1'b1;
                     dneg_d[i] = 1'b1;
                  end
               end
            end
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.ready   = (state == IDLE);
   assign bus.dig_bin = bin_q;
   assign bus.dig_neg = dneg_q;
   assign bus.dig_en  = en_q;

endmodule

// File: tb/tb_sseg_value_driver.sv
// Directed and random stimulus for sseg_value_driver, checked against a decimal
// display model computed with integer arithmetic.
module tb_sseg_value_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total  = 0;

   sseg_value_driver_if bus ();

   sseg_value_driver dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Display expected for a signed value, built from decimal digits
   task automatic model(input int v, output logic [15:0] b, output logic [3:0] n,
                        output logic [3:0] e);
      int mag, nd, t;
      mag = (v < 0) ? -v : v;
      b = '0; n = '0; e = '0;
      if (v < 0 && mag > 999) begin
         n = 4'hF;
         e = 4'hF;
      end else begin
         nd = 0;
         t  = mag;
         do begin
            b[4*nd +: 4] = 4'(t % 10);
            e[nd] = 1'b1;
            t = t / 10;
            nd++;
         end while (t != 0);
         if (v < 0) begin
            e[nd] = 1'b1;
            n[nd] = 1'b1;
         end
      end
   endtask

   task automatic check_display(input string tag, input int v);
      logic [15:0] b;
      logic [3:0]  n, e;
      model(v, b, n, e);
      check({tag, ".bin"}, 32'(bus.dig_bin), 32'(b));
      check({tag, ".neg"}, 32'(bus.dig_neg), 32'(n));
      check({tag, ".en"},  32'(bus.dig_en),  32'(e));
   endtask

   task automatic send(input string tag, input int v);
      int          lows;
      logic        held;
      logic [15:0] b0;
      logic [3:0]  n0, e0;
      @(negedge clk);
      b0 = bus.dig_bin; n0 = bus.dig_neg; e0 = bus.dig_en;
      bus.value = 14'(v);
      bus.valid = 1'b1;
      @(negedge clk);
      bus.valid = 1'b0;
      lows = 0;
      held = 1'b1;
      while (bus.ready !== 1'b1 && lows < 40) begin
         lows++;
         if (bus.dig_bin !== b0 || bus.dig_neg !== n0 || bus.dig_en !== e0)
            held = 1'b0;
         @(negedge clk);
      end
      check({tag, ".busy"}, 32'(lows), 32'd15);
      check({tag, ".hold"}, 32'(held), 32'd1);
      check_display(tag, v);
   endtask

   initial begin
      int q[$];
      int last, v;
      bus.value = '0;
      bus.valid = 1'b0;

      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst.ready", 32'(bus.ready), 32'd1);
      check("rst.bin",   32'(bus.dig_bin), 32'h0);
      check("rst.neg",   32'(bus.dig_neg), 32'h0);
      check("rst.en",    32'(bus.dig_en),  32'h1);

      send("d1234", 1234);
      send("dm5", -5);
      send("d8191", 8191);
      send("d0", 0);
      send("dm1000", -1000);
      send("dm999", -999);
      send("dm8192", -8192);
      send("dm10", -10);
      send("d100", 100);

      for (int i = 0; i < 20; i++) begin
         v = int'($urandom_range(0, 16383)) - 8192;
         send($sformatf("rnd%0d", i), v);
      end

      // valid held high, value changing every cycle
      last = 0;
      for (int cyc = 0; cyc <= 64; cyc++) begin
         @(negedge clk);
         v = int'($urandom_range(0, 16383)) - 8192;
         if (bus.ready === 1'b1) begin
            if (q.size() > 0) begin
               check($sformatf("b2b.gap%0d", cyc), 32'(cyc - last), 32'd16);
               check_display($sformatf("b2b%0d", cyc), q.pop_front());
            end
            if (cyc < 64) begin
               q.push_back(v);
               last = cyc;
            end
         end
         bus.value = 14'(v);
         bus.valid = (cyc < 64);
      end
      check("b2b.drained", 32'(q.size()), 32'd0);

      // reset mid-conversion discards the value
      @(negedge clk);
      bus.value = 14'(4321);
      bus.valid = 1'b1;
      @(negedge clk);
      bus.valid = 1'b0;
      repeat (4) @(negedge clk);
      check("abort.busy", 32'(bus.ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort.ready", 32'(bus.ready), 32'd1);
      check("abort.bin",   32'(bus.dig_bin), 32'h0);
      check("abort.neg",   32'(bus.dig_neg), 32'h0);
      check("abort.en",    32'(bus.dig_en),  32'h1);
      send("d77", 77);

      // reset together with valid in IDLE must not capture
      @(negedge clk);
      rst = 1'b1;
      bus.value = 14'(5);
      bus.valid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.valid = 1'b0;
      @(negedge clk);
      check("rstv.ready", 32'(bus.ready), 32'd1);
      check("rstv.en",    32'(bus.dig_en), 32'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
